// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - fixed-latency pipelined instruction store for the fetch unit
module inst_fetch_responder #(
    parameter int          LATENCY  = 3,
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        request_i,
    input  logic [31:0] instAddr_i,
    input  logic        flush_i,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        ready_o,
    output logic        dataOk_o,
    output logic [31:0] inst_o,
    output logic [31:0] instAddr_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [DEPTH];

    logic [31:0] rd_word_idx;
    logic [31:0] ld_word_idx;
    logic        rd_in_range;
    logic        ld_in_range;
    logic        accept;
    logic [31:0] rd_data;
    logic        unused_load_lsb;

    // Stage k is loaded from stage_* at each edge; the last stage drives the outputs.
    logic [LATENCY-1:0]       pipe_v;
    logic [LATENCY-1:0][31:0] pipe_d;
    logic [LATENCY-1:0][31:0] pipe_a;
    logic [LATENCY-1:0]       stage_v;
    logic [LATENCY-1:0][31:0] stage_d;
    logic [LATENCY-1:0][31:0] stage_a;

    // Byte addresses become word indices; the low two bits never select anything.
    assign rd_word_idx     = {2'b00, instAddr_i[31:2]};
    assign ld_word_idx     = {2'b00, load_addr_i[31:2]};
    assign rd_in_range     = rd_word_idx < 32'(DEPTH);
    assign ld_in_range     = ld_word_idx < 32'(DEPTH);
    assign unused_load_lsb = ^load_addr_i[1:0];

    // A preload write owns the store for its cycle, so fetches wait.
    assign ready_o = ~reset & ~load_we_i;
    assign accept  = request_i & ready_o;
    assign rd_data = rd_in_range ? mem[rd_word_idx[AW-1:0]] : NOP_INST;

    // Preload port; the store itself is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && load_we_i && ld_in_range) begin
            mem[ld_word_idx[AW-1:0]] <= load_data_i;
        end
    end

    // Next contents of each stage: a new accept enters stage 0, older entries die on flush.
    always_comb begin
        stage_v    = '0;
        stage_d    = '0;
        stage_a    = '0;
        stage_v[0] = accept;
        stage_d[0] = rd_data;
        stage_a[0] = instAddr_i;
        for (int k = 1; k < LATENCY; k++) begin
            stage_v[k] = pipe_v[k-1] & ~flush_i;
            stage_d[k] = pipe_d[k-1];
            stage_a[k] = pipe_a[k-1];
        end
    end

    // Shift pipeline; data/address only move with a valid entry so the outputs hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            pipe_d <= '0;
            pipe_a <= '0;
        end else begin
            pipe_v <= stage_v;
            for (int k = 0; k < LATENCY; k++) begin
                if (stage_v[k]) begin
                    pipe_d[k] <= stage_d[k];
                    pipe_a[k] <= stage_a[k];
                end
            end
        end
    end

    assign dataOk_o   = pipe_v[LATENCY-1];
    assign inst_o     = pipe_d[LATENCY-1];
    assign instAddr_o = pipe_a[LATENCY-1];

endmodule
